pipe_ctrl_unit: RTL and testbench

Central pipeline sequencer for the 5-stage core. It collects the load-use stall, the branch-mispredict flush, and the memory and multi-cycle-unit busy signals. From these it drives one advance-enable per pipeline register and a bubble/flush per stage, and it issues the registered PC redirect to fetch. It sits beside the hazard detection unit and owns every stage-enable in the core.

---
 rtl/pipe_ctrl_unit_pkg.sv | 34 +++
 rtl/pipe_ctrl_unit_if.sv | 33 +++
 rtl/pipe_ctrl_perf.sv | 36 +++
 rtl/pipe_ctrl_unit.sv | 181 ++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, widths and
// the per-stage enable/flush patterns it can drive.
package pipe_ctrl_unit_pkg;

    localparam int PIPE_XLEN         = 32;
    localparam int PIPE_FLUSH_CYCLES = 2;
    localparam int FLUSH_CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FREEZE   = 2'd2,
        ST_REDIRECT = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic if_en;
        logic id_en;
        logic ex_en;
        logic mem_en;
        logic wb_en;
        logic id_flush;
        logic ex_flush;
    } stage_ctrl_t;

    // Field order: if, id, ex, mem, wb enables, then id_flush, ex_flush.
    localparam stage_ctrl_t CTRL_BOOT     = 7'b00000_11;
    localparam stage_ctrl_t CTRL_HOLD     = 7'b00000_00;
    localparam stage_ctrl_t CTRL_GO       = 7'b11111_00;
    localparam stage_ctrl_t CTRL_MDU      = 7'b00011_00;
    localparam stage_ctrl_t CTRL_LOAD_USE = 7'b00111_01;
    localparam stage_ctrl_t CTRL_FLUSH    = 7'b11111_11;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Hazard requests into the sequencer and stage controls / PC redirect out of it.
interface pipe_ctrl_unit_if #(
    parameter int XLEN = pipe_ctrl_unit_pkg::PIPE_XLEN
);
    logic            load_use_stall;
    logic            branch_mispredict;
    logic [XLEN-1:0] branch_target;
    logic            dmem_busy;
    logic            mdu_busy;

    logic            if_en;
    logic            id_en;
    logic            ex_en;
    logic            mem_en;
    logic            wb_en;
    logic            id_flush;
    logic            ex_flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      ctrl_state;

    modport master (
        input  load_use_stall, branch_mispredict, branch_target, dmem_busy, mdu_busy,
        output if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush,
        output redirect_valid, redirect_pc, ctrl_state
    );

    modport slave (
        output load_use_stall, branch_mispredict, branch_target, dmem_busy, mdu_busy,
        input  if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush,
        input  redirect_valid, redirect_pc, ctrl_state
    );
endinterface

// File: rtl/pipe_ctrl_perf.sv
// Saturating 32-bit event counters for the pipeline sequencer (one per event bit).
module pipe_ctrl_perf #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        evt,
    output logic [N-1:0][31:0]  count
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            logic [31:0] cnt_q;
            logic [31:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (evt[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign count[gi] = cnt_q;
        end
    endgenerate

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central pipeline sequencer: stage enables/flushes, flush counter and registered
// PC redirect. Define PIPE_CTRL_PERF_EN to add the saturating perf counters.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int XLEN         = PIPE_XLEN,
    parameter int FLUSH_CYCLES = PIPE_FLUSH_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    pipe_ctrl_unit_if.master bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_freeze_cycles,
    output logic [31:0]      perf_flush_events
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [FLUSH_CNT_W-1:0] CNT_ONE    = FLUSH_CNT_W'(1);

    ctrl_state_t            state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   issued_q, issued_d;
    logic                   redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
    stage_ctrl_t            ctrl;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pend_d           = pend_q;
        issued_d         = issued_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        ctrl             = CTRL_HOLD;

        unique case (state_q)
            ST_BOOT: begin
                ctrl    = CTRL_BOOT;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (bus.dmem_busy) begin
                    ctrl    = CTRL_HOLD;
                    state_d = ST_FREEZE;
                    // A mispredict coinciding with the freeze must not be lost.
                    if (bus.branch_mispredict) begin
                        pend_d        = 1'b1;
                        issued_d      = 1'b0;
                        cnt_d         = FLUSH_LOAD;
                        redirect_pc_d = bus.branch_target;
                    end
                end else if (bus.branch_mispredict) begin
                    ctrl             = CTRL_GO;
                    state_d          = ST_REDIRECT;
                    cnt_d            = FLUSH_LOAD;
                    redirect_pc_d    = bus.branch_target;
                    redirect_valid_d = 1'b1;
                    issued_d         = 1'b1;
                end else if (bus.mdu_busy) begin
                    ctrl = CTRL_MDU;
                end else if (bus.load_use_stall) begin
                    ctrl = CTRL_LOAD_USE;
                end else begin
                    ctrl = CTRL_GO;
                end
            end

            ST_FREEZE: begin
                ctrl = CTRL_HOLD;
                if (bus.branch_mispredict) begin
                    pend_d        = 1'b1;
                    issued_d      = 1'b0;
                    cnt_d         = FLUSH_LOAD;
                    redirect_pc_d = bus.branch_target;
                end
                // The exit cycle stays frozen; the next state is chosen from it.
                if (!bus.dmem_busy) begin
                    if (pend_d) begin
                        state_d          = ST_REDIRECT;
                        pend_d           = 1'b0;
                        redirect_valid_d = !issued_d;
                        issued_d         = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_REDIRECT: begin
                if (bus.dmem_busy) begin
                    // Remaining flush count is kept and resumed after the freeze.
                    ctrl    = CTRL_HOLD;
                    state_d = ST_FREEZE;
                    pend_d  = 1'b1;
                    if (bus.branch_mispredict) begin
                        issued_d      = 1'b0;
                        cnt_d         = FLUSH_LOAD;
                        redirect_pc_d = bus.branch_target;
                    end
                end else begin
                    ctrl = CTRL_FLUSH;
                    if (bus.branch_mispredict) begin
                        cnt_d            = FLUSH_LOAD;
                        redirect_pc_d    = bus.branch_target;
                        redirect_valid_d = 1'b1;
                        issued_d         = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q <= CNT_ONE) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_BOOT;
            cnt_q            <= '0;
            pend_q           <= 1'b0;
            issued_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pend_q           <= pend_d;
            issued_q         <= issued_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.if_en          = ctrl.if_en;
    assign bus.id_en          = ctrl.id_en;
    assign bus.ex_en          = ctrl.ex_en;
    assign bus.mem_en         = ctrl.mem_en;
    assign bus.wb_en          = ctrl.wb_en;
    assign bus.id_flush       = ctrl.id_flush;
    assign bus.ex_flush       = ctrl.ex_flush;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.ctrl_state     = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic            stall_evt;
    logic            freeze_evt;
    logic            flush_evt;
    logic [2:0][31:0] perf_count;

    assign stall_evt  = (state_q == ST_RUN) && !bus.dmem_busy && !bus.branch_mispredict &&
                        (bus.mdu_busy || bus.load_use_stall);
    assign freeze_evt = (state_q == ST_FREEZE);
    assign flush_evt  = (state_d == ST_REDIRECT) &&
                        ((state_q != ST_REDIRECT) || bus.branch_mispredict);

    pipe_ctrl_perf #(.N(3)) u_perf (
        .clk     (clk),
        .reset_n (reset_n),
        .evt     ({flush_evt, freeze_evt, stall_evt}),
        .count   (perf_count)
    );

    assign perf_stall_cycles  = perf_count[0];
    assign perf_freeze_cycles = perf_count[1];
    assign perf_flush_events  = perf_count[2];
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed + randomized bench for pipe_ctrl_unit against a behavioural pipeline model.
module tb_pipe_ctrl_unit;

    localparam int XLEN = 32;
    localparam int F    = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    pipe_ctrl_unit_if #(.XLEN(XLEN)) bus_if ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_freeze_cycles;
    logic [31:0] perf_flush_events;
`endif

    pipe_ctrl_unit #(.XLEN(XLEN), .FLUSH_CYCLES(F)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_freeze_cycles (perf_freeze_cycles),
        .perf_flush_events  (perf_flush_events)
`endif
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Behavioural view: is the core still booting, frozen by memory, how many
    // flush cycles are owed, is a redirect waiting out a freeze, is its strobe owed.
    bit          m_booting;
    bit          m_frozen;
    int          m_flush_left;
    bit          m_pend;
    bit          m_owed;
    bit          m_rv;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] obs_ctrl();
        return {bus_if.if_en, bus_if.id_en, bus_if.ex_en, bus_if.mem_en, bus_if.wb_en,
                bus_if.id_flush, bus_if.ex_flush};
    endfunction

    task automatic model_reset();
        m_booting    = 1'b1;
        m_frozen     = 1'b0;
        m_flush_left = 0;
        m_pend       = 1'b0;
        m_owed       = 1'b0;
        m_rv         = 1'b0;
        m_pc         = '0;
    endtask

    // {if,id,ex,mem,wb,id_flush,ex_flush}
    function automatic logic [6:0] model_ctrl(input bit lu, input bit bm, input bit dm, input bit mdu);
        if (m_booting)            return 7'b00000_11;
        if (m_frozen || dm)       return 7'b00000_00;
        if (m_flush_left > 0)     return 7'b11111_11;
        if (bm)                   return 7'b11111_00;
        if (mdu)                  return 7'b00011_00;
        if (lu)                   return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_booting)        return 2'd0;
        if (m_frozen)         return 2'd2;
        if (m_flush_left > 0) return 2'd3;
        return 2'd1;
    endfunction

    task automatic model_step(input bit bm, input logic [31:0] bt, input bit dm);
        bit next_rv;
        next_rv = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_frozen) begin
            if (bm) begin
                m_pc = bt; m_flush_left = F; m_owed = 1'b1; m_pend = 1'b1;
            end
            if (!dm) begin
                m_frozen = 1'b0;
                if (m_pend) begin
                    next_rv = m_owed;
                    m_owed  = 1'b0;
                    m_pend  = 1'b0;
                end
            end
        end else if (dm) begin
            m_frozen = 1'b1;
            if (m_flush_left > 0) m_pend = 1'b1;
            if (bm) begin
                m_pc = bt; m_flush_left = F; m_owed = 1'b1; m_pend = 1'b1;
            end
        end else if (bm) begin
            m_pc = bt; m_flush_left = F; m_owed = 1'b0; next_rv = 1'b1;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
        m_rv = next_rv;
    endtask

    task automatic cycle(input string tag, input bit lu, input bit bm, input logic [31:0] bt,
                         input bit dm, input bit mdu);
        bus_if.load_use_stall    = lu;
        bus_if.branch_mispredict = bm;
        bus_if.branch_target     = bt;
        bus_if.dmem_busy         = dm;
        bus_if.mdu_busy          = mdu;
        #1;
        check({tag, ".ctrl"},  32'(obs_ctrl()),              32'(model_ctrl(lu, bm, dm, mdu)));
        check({tag, ".state"}, 32'(bus_if.ctrl_state),       32'(model_state()));
        check({tag, ".rvalid"}, 32'(bus_if.redirect_valid),  32'(m_rv));
        check({tag, ".rpc"},   bus_if.redirect_pc,           m_pc);
        $display("%0t %-8s lu=%0b bm=%0b bt=%h dm=%0b mdu=%0b | ctrl=%b st=%0d rv=%0b pc=%h",
                 $time, tag, lu, bm, bt, dm, mdu, obs_ctrl(), bus_if.ctrl_state,
                 bus_if.redirect_valid, bus_if.redirect_pc);
        model_step(bm, bt, dm);
        @(negedge clk);
    endtask

    // Registered outputs only, against constants taken straight from the plan.
    task automatic peek(input string tag, input logic [1:0] st, input bit rv, input logic [31:0] pc);
        check({tag, ".state"},  32'(bus_if.ctrl_state),     32'(st));
        check({tag, ".rvalid"}, 32'(bus_if.redirect_valid), 32'(rv));
        check({tag, ".rpc"},    bus_if.redirect_pc,         pc);
        $display("%0t %-8s peek st=%0d rv=%0b pc=%h", $time, tag, bus_if.ctrl_state,
                 bus_if.redirect_valid, bus_if.redirect_pc);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ctrl"},   32'(obs_ctrl()),             32'h03);
        check({tag, ".state"},  32'(bus_if.ctrl_state),      32'd0);
        check({tag, ".rvalid"}, 32'(bus_if.redirect_valid),  32'd0);
        check({tag, ".rpc"},    bus_if.redirect_pc,          32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check({tag, ".pstall"},  perf_stall_cycles,  32'd0);
        check({tag, ".pfreeze"}, perf_freeze_cycles, 32'd0);
        check({tag, ".pflush"},  perf_flush_events,  32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int dm_left;
        bit lu, bm, dm, mdu;
        logic [31:0] bt;

        bus_if.load_use_stall    = 1'b0;
        bus_if.branch_mispredict = 1'b0;
        bus_if.branch_target     = '0;
        bus_if.dmem_busy         = 1'b0;
        bus_if.mdu_busy          = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");

        reset_n = 1'b1;
        model_reset();
        cycle("boot", 0, 0, 0, 0, 0);
        cycle("run", 0, 0, 0, 0, 0);
        cycle("lu", 1, 0, 0, 0, 0);
        cycle("lu_end", 0, 0, 0, 0, 0);

        cycle("bm", 0, 1, 32'h0000_1000, 0, 0);
        peek("bm_n1", 2'd3, 1'b1, 32'h0000_1000);
        cycle("fl1", 0, 0, 0, 0, 0);
        cycle("fl2", 0, 0, 0, 0, 0);
        peek("bm_n3", 2'd1, 1'b0, 32'h0000_1000);
        cycle("run2", 0, 0, 0, 0, 0);

        cycle("dm1", 0, 0, 0, 1, 0);
        cycle("dm2bm", 0, 1, 32'h0000_2000, 1, 0);
        cycle("dm3", 0, 0, 0, 1, 0);
        cycle("dm4", 0, 0, 0, 1, 0);
        cycle("dm_exit", 0, 0, 0, 0, 0);
        peek("dm_rd", 2'd3, 1'b1, 32'h0000_2000);
        cycle("dm_fl1", 0, 0, 0, 0, 0);
        cycle("dm_fl2", 0, 0, 0, 0, 0);
        cycle("run3", 0, 0, 0, 0, 0);

        cycle("mdu_lu", 1, 0, 0, 0, 1);
        cycle("mdu", 0, 0, 0, 0, 1);

        cycle("bm3", 0, 1, 32'h0000_3000, 0, 0);
        cycle("rd_dm", 0, 0, 0, 1, 0);
        cycle("fz", 0, 0, 0, 1, 0);
        cycle("fz_exit", 0, 0, 0, 0, 0);
        peek("resume", 2'd3, 1'b0, 32'h0000_3000);
        cycle("rs_fl1", 0, 0, 0, 0, 0);
        cycle("rs_fl2", 0, 0, 0, 0, 0);
        cycle("run4", 0, 0, 0, 0, 0);

        cycle("bm4", 0, 1, 32'h0000_4000, 0, 0);
        cycle("bm5", 0, 1, 32'h0000_5000, 0, 0);
        peek("reload", 2'd3, 1'b1, 32'h0000_5000);
        cycle("rl_fl1", 0, 0, 0, 0, 0);
        cycle("rl_fl2", 0, 0, 0, 0, 0);
        cycle("run5", 0, 0, 0, 0, 0);

        dm_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (dm_left > 0) begin
                dm = 1'b1;
                dm_left--;
            end else if ($urandom_range(0, 11) == 0) begin
                dm = 1'b1;
                dm_left = int'($urandom_range(0, 4));
            end else begin
                dm = 1'b0;
            end
            bm  = ($urandom_range(0, 7) == 0);
            mdu = ($urandom_range(0, 4) == 0);
            lu  = ($urandom_range(0, 4) == 0);
            bt  = $urandom & 32'hFFFF_FFFC;
            cycle("rnd", lu, bm, bt, dm, mdu);
        end
        for (int i = 0; i < 8; i++) cycle("drain", 0, 0, 0, 0, 0);

        cycle("bm6", 0, 1, 32'h0000_6000, 0, 0);
        bus_if.branch_mispredict = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cycle("boot2", 0, 0, 0, 0, 0);
        cycle("run6", 0, 0, 0, 0, 0);
        peek("no_rd", 2'd1, 1'b0, 32'h0000_0000);
        cycle("run7", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
